// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state codes, parameter defaults and helpers shared by the sequencer, board tops and the bench.
// Revision 1.0
`default_nettype none

package reset_sequencer_pkg;

  localparam int DEF_CNT_W           = 16;
  localparam int DEF_HOLD_CYCLES     = 32;
  localparam int DEF_STAGE_GAP       = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  localparam logic [2:0] ST_WAIT_LOCK  = 3'd0;
  localparam logic [2:0] ST_HOLD       = 3'd1;
  localparam logic [2:0] ST_REL_PERIPH = 3'd2;
  localparam logic [2:0] ST_RUN        = 3'd3;
  localparam logic [2:0] ST_KEY_HELD   = 3'd4;

  // States that run the shared delay counter.
  function automatic logic is_timed_state(input logic [2:0] st);
    return (st == ST_HOLD) || (st == ST_REL_PERIPH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus symmetric debounce for an active-low push-button.
// Revision 1.0
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_key_pressed
);

  localparam int              c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

  logic              r_key_meta;
  logic              r_key_s;
  logic [c_DB_W-1:0] r_cnt;
  logic              r_pressed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_meta <= 1'b1;
      r_key_s    <= 1'b1;
      r_cnt      <= '0;
      r_pressed  <= 1'b0;
    end else begin
      r_key_meta <= i_key_n;
      r_key_s    <= r_key_meta;
      // key_s equal to pressed means the sample disagrees with the debounced level.
      if (r_key_s == r_pressed) begin
        if (r_cnt == c_DB_LAST) begin
          r_pressed <= ~r_pressed;
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + c_DB_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_key_pressed = r_pressed;

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// reset_sequencer: PLL-lock and push-button driven staged release of peripheral and CPU resets.
// Revision 1.0
`default_nettype none

module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP       = DEF_STAGE_GAP,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       key_n,
  output logic       periph_reset,
  output logic       cpu_reset,
  output logic       ready,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic             r_lock_meta;
  logic             r_locked_s;
  logic             w_key_pressed;
  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_periph_reset;
  logic             r_cpu_reset;
  logic             r_ready;
  logic             w_periph_nxt;
  logic             w_cpu_nxt;
  logic             w_ready_nxt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_key_n      (key_n),
    .o_key_pressed(w_key_pressed)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta    <= 1'b0;
      r_locked_s     <= 1'b0;
      r_state        <= ST_WAIT_LOCK;
      r_cnt          <= '0;
      r_periph_reset <= 1'b1;
      r_cpu_reset    <= 1'b1;
      r_ready        <= 1'b0;
    end else begin
      r_lock_meta    <= pll_locked;
      r_locked_s     <= r_lock_meta;
      r_state        <= w_next;
      r_cnt          <= w_cnt_nxt;
      r_periph_reset <= w_periph_nxt;
      r_cpu_reset    <= w_cpu_nxt;
      r_ready        <= w_ready_nxt;
    end
  end

  // Lock loss outranks every other transition, including a key press.
  always_comb begin
    w_next = r_state;
    if (!r_locked_s) begin
      w_next = ST_WAIT_LOCK;
    end else begin
      case (r_state)
        ST_WAIT_LOCK:  w_next = ST_HOLD;
        ST_HOLD: begin
          if (w_key_pressed)             w_next = ST_KEY_HELD;
          else if (r_cnt == c_HOLD_LAST) w_next = ST_REL_PERIPH;
        end
        ST_REL_PERIPH: begin
          if (w_key_pressed)            w_next = ST_KEY_HELD;
          else if (r_cnt == c_GAP_LAST) w_next = ST_RUN;
        end
        ST_RUN: begin
          if (w_key_pressed) w_next = ST_KEY_HELD;
        end
        ST_KEY_HELD: begin
          if (!w_key_pressed) w_next = ST_HOLD;
        end
        default:       w_next = ST_WAIT_LOCK;
      endcase
    end
  end

  // Outputs and counter are decoded from next-state so they move on the same edge as state.
  always_comb begin
    w_periph_nxt = 1'b1;
    w_cpu_nxt    = 1'b1;
    w_ready_nxt  = 1'b0;
    w_cnt_nxt    = '0;
    case (w_next)
      ST_REL_PERIPH: w_periph_nxt = 1'b0;
      ST_RUN: begin
        w_periph_nxt = 1'b0;
        w_cpu_nxt    = 1'b0;
        w_ready_nxt  = 1'b1;
      end
      default: ;
    endcase
    if (is_timed_state(w_next) && (w_next == r_state)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign periph_reset = r_periph_reset;
  assign cpu_reset    = r_cpu_reset;
  assign ready        = r_ready;
  assign state        = r_state;

endmodule

`default_nettype wire
